// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: FSM encoding,
// peripheral address windows, select codes and the queued request format.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] S0_BASE  = 32'h8000_0000;
  localparam logic [31:0] S0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] S1_BASE  = 32'h8400_0000;
  localparam logic [31:0] S1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h8800_0000;
  localparam logic [31:0] S2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_S0   = 3'b001;
  localparam logic [2:0] PSEL_S1   = 3'b010;
  localparam logic [2:0] PSEL_S2   = 3'b100;

  localparam int unsigned WS_CNT_W = 3;

  // 65-bit queue entry: {write, addr, wdata}
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_req_t;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// Two-entry request queue between the AHB handshake and the APB sequencer.
// Full is derived from the registered count, so a pop frees space one cycle later.
module apb_req_fifo
  import apb_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  apb_req_t data_i,
  output apb_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  apb_req_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push_ok_s;
  logic       pop_ok_s;

  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Occupancy update; simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= apb_req_t'(65'd0);
      mem_q[1] <= apb_req_t'(65'd0);
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == 2'(DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/apb_controller.sv
// APB master sequencer: queues AHB-decoded requests, decodes the peripheral
// select and runs SETUP/ACCESS with a fixed wait-state count, then reports back.
module apb_controller
  import apb_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  pselx,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  localparam logic [WS_CNT_W-1:0] WS_LAST = WS_CNT_W'(WAIT_STATES);

  state_e              state_q;
  logic [WS_CNT_W-1:0] cnt_q;
  logic                pwrite_q;
  logic                penable_q;
  logic [2:0]          pselx_q;
  logic [31:0]         paddr_q;
  logic [31:0]         pwdata_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  apb_req_t   head_s;
  apb_req_t   push_data_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       fifo_pop_s;
  logic [2:0] head_sel_s;
  logic       head_err_s;

  assign push_data_s = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready   = !fifo_full_s;

  apb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (hclk),
    .rst_i   (hreset),
    .push_i  (req_valid),
    .pop_i   (fifo_pop_s),
    .data_i  (push_data_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Peripheral select for the queue head; no window hit means a decode error
  always_comb begin
    head_sel_s = PSEL_NONE;
    if (in_window(head_s.addr, S0_BASE, S0_LIMIT)) begin
      head_sel_s = PSEL_S0;
    end else if (in_window(head_s.addr, S1_BASE, S1_LIMIT)) begin
      head_sel_s = PSEL_S1;
    end else if (in_window(head_s.addr, S2_BASE, S2_LIMIT)) begin
      head_sel_s = PSEL_S2;
    end else begin
      head_sel_s = PSEL_NONE;
    end
  end

  assign head_err_s = (head_sel_s == PSEL_NONE);
  assign fifo_pop_s = !fifo_empty_s && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  // Transfer sequencer; paddr/pwrite/pwdata only load on a mapped pop so they hold between transfers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pselx_q     <= PSEL_NONE;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          penable_q <= 1'b0;
          pselx_q   <= PSEL_NONE;
          if (fifo_pop_s && head_err_s) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (fifo_pop_s) begin
            state_q  <= ST_SETUP;
            pselx_q  <= head_sel_s;
            paddr_q  <= head_s.addr;
            pwrite_q <= head_s.write;
            pwdata_q <= head_s.wdata;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ST_ACCESS: begin
          if (cnt_q == WS_LAST) begin
            state_q     <= ST_RESP;
            penable_q   <= 1'b0;
            pselx_q     <= PSEL_NONE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? 32'h0000_0000 : prdata;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          penable_q <= 1'b0;
          pselx_q   <= PSEL_NONE;
        end
      endcase
    end
  end

  assign pwrite    = pwrite_q;
  assign penable   = penable_q;
  assign pselx     = pselx_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: two instances (0 and 2 wait states) driven by
// directed and random requests, checked against a transaction-level model.
module tb_apb_controller;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];
  logic        pwrite    [2];
  logic        penable   [2];
  logic [2:0]  pselx     [2];
  logic [31:0] paddr     [2];
  logic [31:0] pwdata    [2];
  logic        ovr_en;
  logic [31:0] ovr_val;

  int n_cmp = 0;
  int n_bad = 0;
  int viol [2];

  typedef struct packed { bit w; bit [31:0] a; bit [31:0] d; } exp_t;
  typedef struct packed {
    bit w; bit [31:0] a; bit [31:0] d; bit [2:0] sel;
    bit [7:0] setup_n; bit [7:0] access_n; bit err; bit [31:0] rdata;
  } obs_t;

  exp_t exp_q [2][$];
  obs_t obs_q [2][$];

  always #5 hclk = ~hclk;

  // Slave read data as a fixed function of the address
  function automatic logic [31:0] slave_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Peripheral index from 64 MiB windows starting at 0x8000_0000
  function automatic logic [2:0] model_sel(input logic [31:0] a);
    logic [31:0] idx;
    if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
    idx = (a - 32'h8000_0000) / 32'h0400_0000;
    return 3'b001 << idx[1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic [31:0] prd;
    bit   [7:0]  setup_n, access_n;
    bit   [2:0]  sel_seen;
    bit   [31:0] a_seen, d_seen;
    bit          w_seen;

    assign prd = ovr_en ? ovr_val : slave_f(paddr[g]);

    apb_controller #(.WAIT_STATES(g * 2), .FIFO_DEPTH(2)) u_dut (
      .hclk(hclk), .hreset(hreset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_err(rsp_err[g]), .rsp_rdata(rsp_rdata[g]),
      .pwrite(pwrite[g]), .penable(penable[g]), .pselx(pselx[g]),
      .paddr(paddr[g]), .pwdata(pwdata[g]), .prdata(prd)
    );

    // Collapse the APB trace of each transfer into one observed record
    always @(negedge hclk) begin
      if (hreset) begin
        setup_n  <= 8'd0;
        access_n <= 8'd0;
      end else if (rsp_valid[g]) begin
        obs_q[g].push_back('{w: w_seen, a: a_seen, d: d_seen, sel: sel_seen,
                             setup_n: setup_n, access_n: access_n,
                             err: rsp_err[g], rdata: rsp_rdata[g]});
        setup_n  <= 8'd0;
        access_n <= 8'd0;
      end else begin
        if (pselx[g] != 3'b000 && !penable[g]) begin
          setup_n  <= setup_n + 8'd1;
          sel_seen <= pselx[g];
          a_seen   <= paddr[g];
          d_seen   <= pwdata[g];
          w_seen   <= pwrite[g];
        end
        if (penable[g]) access_n <= access_n + 8'd1;
      end
    end

    // Cycle-level protocol rules that must hold in every cycle
    always @(negedge hclk) begin
      if (!hreset) begin
        if ((!rsp_valid[g] && (rsp_err[g] || rsp_rdata[g] != 32'd0)) ||
            (penable[g] && (pselx[g] == 3'b000 || pselx[g] != sel_seen)) ||
            (rsp_valid[g] && (pselx[g] != 3'b000 || penable[g])) ||
            ($countones(pselx[g]) > 1))
          viol[g] <= viol[g] + 1;
      end
    end
  end

  task automatic flush(input int u);
    exp_q[u].delete();
    obs_q[u].delete();
  endtask

  task automatic push(input int u, input bit w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge hclk);
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a; req_wdata[u] = d;
    while (!req_ready[u] && n < 200) begin @(negedge hclk); n++; end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout u=%0d: req_ready stayed %b, required 1", u, req_ready[u]);
      req_valid[u] = 1'b0;
    end else begin
      @(posedge hclk);
      exp_q[u].push_back('{w: w, a: a, d: d});
      #1 req_valid[u] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int u);
    int n = 0;
    while (obs_q[u].size() < exp_q[u].size() && n < 1000) begin @(negedge hclk); n++; end
    if (n >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout u=%0d: %0d responses, required %0d", u, obs_q[u].size(), exp_q[u].size());
    end
    repeat (4) @(negedge hclk);
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 32'd0; req_wdata[u] = 32'd0;
    end
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if ({rsp_valid[u], rsp_err[u], rsp_rdata[u], pwrite[u], penable[u], pselx[u], paddr[u], pwdata[u]} !== 103'd0) begin
        n_bad++; $display("FAIL reset_outputs u=%0d: pselx=%b paddr=%h rsp_valid=%b, required all 0", u, pselx[u], paddr[u], rsp_valid[u]);
      end
      n_cmp++;
      if (req_ready[u] !== 1'b1) begin n_bad++; $display("FAIL reset_ready u=%0d: got %b, required 1", u, req_ready[u]); end
    end
    hreset = 1'b0;
    flush(0); flush(1);
  endtask

  task automatic test_single_write();
    logic [24:0] trace = 25'd0;
    logic        w_k1 = 1'b0;
    logic [31:0] a_k1 = 32'd0, d_k1 = 32'd0, rd_k3 = 32'hFFFF_FFFF;
    logic        err_k3 = 1'b1;
    push(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      @(negedge hclk);
      trace = {trace[19:0], pselx[0], penable[0], rsp_valid[0]};
      if (k == 1) begin w_k1 = pwrite[0]; a_k1 = paddr[0]; d_k1 = pwdata[0]; end
      if (k == 3) begin err_k3 = rsp_err[0]; rd_k3 = rsp_rdata[0]; end
    end
    n_cmp++;
    if (trace !== {5'b000_0_0, 5'b001_0_0, 5'b001_1_0, 5'b000_0_1, 5'b000_0_0}) begin
      n_bad++; $display("FAIL write_timing: trace {sel,en,rv}x5 = %b, required 0000000100001100000100000", trace);
    end
    n_cmp++;
    if ({w_k1, a_k1, d_k1} !== {1'b1, 32'h8000_0010, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL write_setup: pwrite=%b paddr=%h pwdata=%h, required 1 80000010 deadbeef", w_k1, a_k1, d_k1);
    end
    n_cmp++;
    if ({err_k3, rd_k3} !== 33'd0) begin
      n_bad++; $display("FAIL write_resp: rsp_err=%b rsp_rdata=%h, required 0 0", err_k3, rd_k3);
    end
    flush(0);
  endtask

  task automatic test_single_read();
    int          pen_n = 0, rsp_n = 0;
    logic [2:0]  sel_or = 3'd0;
    logic        w_setup = 1'b1, err_r = 1'b1;
    logic [31:0] rd = 32'd0;
    ovr_en = 1'b1; ovr_val = 32'h0000_0025;
    push(1, 1'b0, 32'h8400_0004, $urandom);
    for (int k = 0; k < 12; k++) begin
      @(negedge hclk);
      if (penable[1]) begin pen_n++; sel_or = sel_or | pselx[1]; end
      if (pselx[1] != 3'b000 && !penable[1]) w_setup = pwrite[1];
      if (rsp_valid[1]) begin rsp_n++; rd = rsp_rdata[1]; err_r = rsp_err[1]; end
    end
    ovr_en = 1'b0;
    n_cmp++; if (pen_n !== 3) begin n_bad++; $display("FAIL read_penable_cycles: got %0d, required 3", pen_n); end
    n_cmp++; if (sel_or !== 3'b010) begin n_bad++; $display("FAIL read_pselx: got %b, required 010", sel_or); end
    n_cmp++; if (w_setup !== 1'b0) begin n_bad++; $display("FAIL read_pwrite: got %b, required 0", w_setup); end
    n_cmp++; if (rsp_n !== 1) begin n_bad++; $display("FAIL read_rsp_count: got %0d, required 1", rsp_n); end
    n_cmp++;
    if ({err_r, rd} !== {1'b0, 32'h0000_0025}) begin
      n_bad++; $display("FAIL read_data: rsp_err=%b rsp_rdata=%h, required 0 00000025", err_r, rd);
    end
    flush(1);
  endtask

  task automatic test_unmapped();
    for (int u = 0; u < 2; u++) begin
      int          rsp_n = 0;
      logic        apb_seen = 1'b0, err_r = 1'b0;
      logic [31:0] rd = 32'hFFFF_FFFF;
      push(u, 1'b0, 32'h9000_0000, $urandom);
      for (int k = 0; k < 8; k++) begin
        @(negedge hclk);
        if (pselx[u] != 3'b000 || penable[u]) apb_seen = 1'b1;
        if (rsp_valid[u]) begin rsp_n++; err_r = rsp_err[u]; rd = rsp_rdata[u]; end
      end
      n_cmp++; if (apb_seen !== 1'b0) begin n_bad++; $display("FAIL unmapped_apb u=%0d: APB cycle seen, required none", u); end
      n_cmp++; if (rsp_n !== 1) begin n_bad++; $display("FAIL unmapped_rsp_count u=%0d: got %0d, required 1", u, rsp_n); end
      n_cmp++;
      if ({err_r, rd} !== {1'b1, 32'd0}) begin
        n_bad++; $display("FAIL unmapped_rsp u=%0d: rsp_err=%b rsp_rdata=%h, required 1 0", u, err_r, rd);
      end
      flush(u);
    end
  endtask

  task automatic test_back_to_back();
    for (int u = 0; u < 2; u++) begin
      int vbase = viol[u];
      flush(u);
      push(u, 1'b1, 32'h8000_0000, $urandom);
      push(u, 1'b1, 32'h8400_0000, $urandom);
      push(u, 1'b1, 32'h8800_0000, $urandom);
      @(negedge hclk);
      n_cmp++;
      if (req_ready[u] !== 1'b0) begin n_bad++; $display("FAIL b2b_full u=%0d: req_ready=%b, required 0", u, req_ready[u]); end
      wait_drain(u);
      n_cmp++;
      if (obs_q[u].size() !== 3) begin n_bad++; $display("FAIL b2b_count u=%0d: got %0d, required 3", u, obs_q[u].size()); end
      for (int i = 0; i < 3 && i < obs_q[u].size(); i++) begin
        n_cmp++;
        if ({obs_q[u][i].sel, obs_q[u][i].err, obs_q[u][i].setup_n, obs_q[u][i].access_n} !==
            {3'b001 << i, 1'b0, 8'd1, 8'(u * 2 + 1)}) begin
          n_bad++; $display("FAIL b2b_xfer u=%0d #%0d: sel=%b err=%b setup=%0d access=%0d, required sel=%b err=0 setup=1 access=%0d",
                            u, i, obs_q[u][i].sel, obs_q[u][i].err, obs_q[u][i].setup_n, obs_q[u][i].access_n, 3'b001 << i, u * 2 + 1);
        end
      end
      n_cmp++;
      if (req_ready[u] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_back u=%0d: got %b, required 1", u, req_ready[u]); end
      n_cmp++;
      if (viol[u] !== vbase) begin n_bad++; $display("FAIL b2b_protocol u=%0d: %0d violations, required 0", u, viol[u] - vbase); end
      flush(u);
    end
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    flush(1);
    push(1, 1'b1, 32'h8800_0008, $urandom);
    push(1, 1'b0, 32'h8000_0100, $urandom);
    while (!penable[1] && n < 20) begin @(negedge hclk); n++; end
    if (n >= 20) begin n_cmp++; n_bad++; $display("FAIL rst_mid_wait: penable never rose, required 1"); end
    hreset = 1'b1;
    @(negedge hclk);
    n_cmp++;
    if ({rsp_valid[1], rsp_err[1], rsp_rdata[1], pwrite[1], penable[1], pselx[1], paddr[1], pwdata[1], req_ready[1]} !== {103'd0, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid_outputs: pselx=%b penable=%b paddr=%h req_ready=%b, required 0 0 0 1", pselx[1], penable[1], paddr[1], req_ready[1]);
    end
    hreset = 1'b0;
    flush(1);
    repeat (10) @(negedge hclk);
    n_cmp++;
    if (obs_q[1].size() !== 0) begin n_bad++; $display("FAIL rst_mid_no_rsp: %0d responses, required 0", obs_q[1].size()); end
    flush(1);
    push(1, 1'b0, 32'h8400_0040, $urandom);
    wait_drain(1);
    n_cmp++;
    if (obs_q[1].size() !== 1) begin
      n_bad++; $display("FAIL rst_mid_recover_count: got %0d, required 1", obs_q[1].size());
    end else if ({obs_q[1][0].sel, obs_q[1][0].err, obs_q[1][0].rdata} !== {3'b010, 1'b0, slave_f(32'h8400_0040)}) begin
      n_bad++; $display("FAIL rst_mid_recover: sel=%b err=%b rdata=%h, required 010 0 %h",
                        obs_q[1][0].sel, obs_q[1][0].err, obs_q[1][0].rdata, slave_f(32'h8400_0040));
    end
    flush(1);
  endtask

  task automatic test_random();
    logic [31:0] edges [7] = '{32'h83FF_FFFF, 32'h8400_0000, 32'h87FF_FFFC, 32'h8800_0000,
                               32'h8BFF_FFFF, 32'h7FFF_FFFF, 32'h8C00_0000};
    for (int u = 0; u < 2; u++) begin
      int vbase = viol[u];
      flush(u);
      for (int i = 0; i < 24; i++) begin
        int unsigned r = $urandom_range(0, 7);
        logic [31:0] a;
        if (r < 4) a = 32'h8000_0000 + (r % 3) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFF);
        else if (r < 6) a = edges[$urandom_range(0, 6)];
        else a = $urandom;
        push(u, 1'($urandom), a, $urandom);
        repeat ($urandom_range(0, 3)) @(negedge hclk);
      end
      wait_drain(u);
      n_cmp++;
      if (obs_q[u].size() !== exp_q[u].size()) begin
        n_bad++; $display("FAIL rand_count u=%0d: got %0d, required %0d", u, obs_q[u].size(), exp_q[u].size());
      end
      for (int i = 0; i < exp_q[u].size() && i < obs_q[u].size(); i++) begin
        exp_t        e = exp_q[u][i];
        obs_t        o = obs_q[u][i];
        logic [2:0]  s = model_sel(e.a);
        logic        er = (s == 3'b000);
        logic [31:0] rd = (er || e.w) ? 32'd0 : slave_f(e.a);
        n_cmp++;
        if ({o.err, o.rdata} !== {er, rd}) begin
          n_bad++; $display("FAIL rand_rsp u=%0d #%0d addr=%h: err=%b rdata=%h, required %b %h", u, i, e.a, o.err, o.rdata, er, rd);
        end
        n_cmp++;
        if (er && {o.setup_n, o.access_n} !== 16'd0) begin
          n_bad++; $display("FAIL rand_err_apb u=%0d #%0d addr=%h: setup=%0d access=%0d, required 0 0", u, i, e.a, o.setup_n, o.access_n);
        end else if (!er && {o.sel, o.setup_n, o.access_n, o.w, o.a, o.d} !== {s, 8'd1, 8'(u * 2 + 1), e.w, e.a, e.d}) begin
          n_bad++; $display("FAIL rand_apb u=%0d #%0d: sel=%b setup=%0d access=%0d w=%b a=%h d=%h, required %b 1 %0d %b %h %h",
                            u, i, o.sel, o.setup_n, o.access_n, o.w, o.a, o.d, s, u * 2 + 1, e.w, e.a, e.d);
        end
      end
      n_cmp++;
      if (viol[u] !== vbase) begin n_bad++; $display("FAIL rand_protocol u=%0d: %0d violations, required 0", u, viol[u] - vbase); end
      flush(u);
    end
  endtask

  initial begin
    viol[0] = 0; viol[1] = 0;
    ovr_en = 1'b0; ovr_val = 32'd0;
    test_reset();
    test_single_write();
    test_single_read();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
